// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, LATENCY wait cycles, then a response.
// Optional performance counters (rd_count, wr_count, err_count) are built when DMEM_PERF_EN is defined.
module dmem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] err_count
`endif
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic          rsp_err_reg;

    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [2:0]    ctrl_reg;

    // With LATENCY=0 the request commits on its acceptance edge, so the
    // datapath works on the live inputs in IDLE and on the latched copy otherwise.
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_ctrl;

    always_comb begin
        if (state_reg == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_ctrl  = req_ctrl;
        end else begin
            cur_we    = we_reg;
            cur_addr  = addr_reg;
            cur_wdata = wdata_reg;
            cur_ctrl  = ctrl_reg;
        end
    end

    logic accept;
    logic enter_resp;
    logic handshake;

    assign accept     = req_valid && req_ready_reg;
    assign enter_resp = reset && ((accept && (LATENCY == 0)) ||
                                  (state_reg == ST_WAIT && cnt_reg == '0));
    assign handshake  = (state_reg == ST_RESP) && rsp_ready;

    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          ctrl_bad;
    logic          misaligned;
    logic          out_of_range;
    logic          cur_err;
    logic [AW-1:0] word_idx;

    always_comb begin
        is_byte      = (cur_ctrl[1:0] == 2'b00);
        is_half      = (cur_ctrl[1:0] == 2'b01);
        is_word      = (cur_ctrl[1:0] == 2'b10);
        ctrl_bad     = (cur_ctrl == 3'b011) || (cur_ctrl == 3'b110) ||
                       (cur_ctrl == 3'b111) || (cur_ctrl[2] && cur_we);
        misaligned   = (is_half && cur_addr[0]) || (is_word && cur_addr[1:0] != 2'b00);
        out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(MEM_WORDS));
        cur_err      = ctrl_bad || misaligned || out_of_range;
        word_idx     = cur_addr[AW+1:2];
    end

    // One byte-wide RAM per lane gives per-byte write enables without read-modify-write.
    logic [31:0] rd_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);

        logic [7:0] lane_mem [MEM_WORDS] = '{default: 8'h00};
        logic [7:0] lane_rdata_reg;
        logic       lane_sel;
        logic [7:0] lane_wbyte;

        always_comb begin
            lane_sel = is_word ||
                       (is_half && cur_addr[1] == LANE[1]) ||
                       (is_byte && cur_addr[1:0] == LANE);
            if (is_word) begin
                lane_wbyte = cur_wdata[gi*8 +: 8];
            end else if (is_half) begin
                lane_wbyte = cur_wdata[(gi%2)*8 +: 8];
            end else begin
                lane_wbyte = cur_wdata[7:0];
            end
        end

        always_ff @(posedge clk) begin
            if (enter_resp && !cur_err) begin
                if (cur_we && lane_sel) begin
                    lane_mem[word_idx] <= lane_wbyte;
                end
                if (!cur_we) begin
                    lane_rdata_reg <= lane_mem[word_idx];
                end
            end
        end

        assign rd_word[gi*8 +: 8] = lane_rdata_reg;
    end

    // Lane extraction uses the latched request, which is frozen during RESP.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    always_comb begin
        sel_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
        sel_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (ctrl_reg[1:0])
            2'b00:   load_ext = {{24{~ctrl_reg[2] & sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = {{16{~ctrl_reg[2] & sel_half[15]}}, sel_half};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg        <= req_we;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        ctrl_reg      <= req_ctrl;
                        req_ready_reg <= 1'b0;
                        if (LATENCY == 0) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= cur_err;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CW'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= cur_err;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    // Stores and rejected requests report zero data; the lane registers may hold an older load.
    assign rsp_rdata = (rsp_valid_reg && !rsp_err_reg && !we_reg) ? load_ext : 32'h0;

`ifdef DMEM_PERF_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;
    logic [31:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count_reg  <= '0;
            wr_count_reg  <= '0;
            err_count_reg <= '0;
        end else if (handshake) begin
            if (rsp_err_reg) begin
                if (err_count_reg != 32'hFFFF_FFFF) err_count_reg <= err_count_reg + 32'd1;
            end else if (we_reg) begin
                if (wr_count_reg != 32'hFFFF_FFFF) wr_count_reg <= wr_count_reg + 32'd1;
            end else begin
                if (rd_count_reg != 32'hFFFF_FFFF) rd_count_reg <= rd_count_reg + 32'd1;
            end
        end
    end

    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;
    assign err_count = err_count_reg;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance checked every cycle against a transaction model,
// plus a LATENCY=0 instance sharing the same request stream, with directed literal expectations.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int MW  = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

`ifdef DMEM_PERF_EN
    logic [31:0] rd_c, wr_c, er_c, z_rd_c, z_wr_c, z_er_c;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_PERF_EN
        , .rd_count(rd_c), .wr_count(wr_c), .err_count(er_c)
`endif
    );

    dmem_responder #(.MEM_WORDS(MW), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(z_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_PERF_EN
        , .rd_count(z_rd_c), .wr_count(z_wr_c), .err_count(z_er_c)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0] mem_m [0:1023];
    initial for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;

    // Returns {err, rdata}; applies stores to the byte model.
    function automatic logic [32:0] model_exec(input logic we, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [2:0] c);
        int sz;
        bit sgn;
        bit bad;
        logic [31:0] v;
        bad = 0; sz = 1; sgn = 0; v = '0;
        case (c)
            3'b000: begin sz = 1; sgn = 1; end
            3'b001: begin sz = 2; sgn = 1; end
            3'b010: sz = 4;
            3'b100: sz = 1;
            3'b101: sz = 2;
            default: bad = 1;
        endcase
        if (we && c[2]) bad = 1;
        if ((a % 32'(sz)) != 0) bad = 1;
        if ((a >> 2) >= 32'(MW)) bad = 1;
        if (bad) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < sz; i++) mem_m[a + 32'(i)] = wd[8*i +: 8];
            return 33'h0;
        end
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[a + 32'(i)];
        if (sgn && v[8*sz-1]) for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
        return {1'b0, v};
    endfunction

    bit          live = 0;
    bit          m_busy, m_resp;
    int          m_left;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_ctrl;
    logic        exp_ready = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    always @(posedge clk) begin
        if (!reset) begin
            live = 1; m_busy = 0; m_resp = 0; m_left = 0;
            exp_ready = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
        end else if (live) begin
            if (m_resp) begin
                if (rsp_ready) begin
                    m_resp = 0; m_busy = 0; exp_ready = 1'b1; exp_valid = 1'b0;
                end
            end else if (m_busy) begin
                m_left--;
                if (m_left <= 0) begin
                    {exp_err, exp_rdata} = model_exec(m_we, m_addr, m_wdata, m_ctrl);
                    m_resp = 1; exp_valid = 1'b1;
                end
            end else if (req_valid) begin
                m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_ctrl = req_ctrl;
                m_busy = 1; exp_ready = 1'b0; m_left = LAT;
                if (m_left == 0) begin
                    {exp_err, exp_rdata} = model_exec(m_we, m_addr, m_wdata, m_ctrl);
                    m_resp = 1; exp_valid = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("cyc_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk("cyc_rsp_rdata", rsp_rdata, exp_rdata);
                chk("cyc_rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] c, input logic [31:0] exp_rd, input logic exp_e,
                       input bit chk0);
        int lat;
        wait_ready("txn");
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_ctrl = c;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (chk0) begin
            chk("l0_rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
            chk("l0_rsp_rdata", z_rsp_rdata, exp_rd);
            chk("l0_rsp_err", {31'b0, z_rsp_err}, {31'b0, exp_e});
        end
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("txn_latency", 32'(lat), 32'(LAT + 1));
        chk("txn_rdata", rsp_rdata, exp_rd);
        chk("txn_err", {31'b0, rsp_err}, {31'b0, exp_e});
        $display("txn we=%0d addr=%h wdata=%h ctrl=%b -> rdata=%h err=%0d lat=%0d",
                 we, a, wd, c, rsp_rdata, rsp_err, lat);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] held;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_ctrl = 3'b010; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_l0_req_ready", {31'b0, z_req_ready}, 32'd1);
        chk("rst_l0_rsp_valid", {31'b0, z_rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1);
        txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1);
        txn(1'b1, 32'h20, 32'h8081_7F01, 3'b010, 32'h0, 1'b0, 1);
        txn(1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 1);
        txn(1'b0, 32'h23, 32'h0, 3'b100, 32'h00000080, 1'b0, 1);
        txn(1'b0, 32'h20, 32'h0, 3'b001, 32'h00007F01, 1'b0, 1);
        txn(1'b0, 32'h22, 32'h0, 3'b101, 32'h00008081, 1'b0, 1);
        txn(1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0, 1);
        txn(1'b1, 32'h21, 32'h000000AA, 3'b000, 32'h0, 1'b0, 1);
        txn(1'b0, 32'h20, 32'h0, 3'b010, 32'h1122AA44, 1'b0, 1);
        txn(1'b0, 32'h22, 32'h0, 3'b010, 32'h0, 1'b1, 1);
        txn(1'b1, 32'h400, 32'h55, 3'b010, 32'h0, 1'b1, 1);
        txn(1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1, 1);
        txn(1'b1, 32'h20, 32'hFF, 3'b100, 32'h0, 1'b1, 1);
        txn(1'b0, 32'h21, 32'h0, 3'b001, 32'h0, 1'b1, 1);
        txn(1'b0, 32'h20, 32'h0, 3'b010, 32'h1122AA44, 1'b0, 1);
        txn(1'b1, 32'h22, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, 1);
        txn(1'b0, 32'h20, 32'h0, 3'b010, 32'hBEEFAA44, 1'b0, 1);
        txn(1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, 1);
        txn(1'b0, 32'h3FC, 32'h0, 3'b010, 32'h0, 1'b0, 1);

        // Backpressure: response held for several cycles, then released.
        wait_ready("bp");
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_ctrl = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = rsp_rdata;
        chk("bp_first_rdata", held, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata_stable", rsp_rdata, held);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        $display("txn backpressure held rdata=%h valid=%0d", rsp_rdata, rsp_valid);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_release_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset while the store is still waiting: nothing may be written.
        wait_ready("rst");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678;
        req_ctrl = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstw_in_wait", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstw_rsp_rdata", rsp_rdata, 32'd0);
        chk("rstw_rsp_err", {31'b0, rsp_err}, 32'd0);
        $display("txn reset-in-wait ready=%0d valid=%0d", req_ready, rsp_valid);
        reset = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the load/store path that the single-cycle core drives combinationally today.
- Accepts one request at a time (address, write data, DMCtrl-encoded size/sign, write enable), waits a programmable number of cycles, then returns read data or a write acknowledgement with an error flag.
- Sits behind the core's data port; used for the upcoming multi-cycle core and for modelling slow memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the array; word index = req_addr[31:2].
- LATENCY, 2, extra wait cycles between acceptance and response; 0 is legal.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- req_ctrl  input  3  DMCtrl: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was rejected.

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge N, latch we/addr/wdata/ctrl. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: counter runs from LATENCY-1 down to 0. Go to RESP on the edge where the counter equals 0.
  - RESP: rsp_valid=1. On rsp_valid&&rsp_ready, go to IDLE.
- Latency: rsp_valid first high in the cycle after edge N+LATENCY. With LATENCY=0, it is high in the cycle directly after acceptance.
- No same-cycle turnaround: req_ready rises in the cycle after the response handshake, giving a minimum of LATENCY+2 cycles per transaction.
- Error checks are evaluated on the latched request:
  - illegal ctrl: 011, 110, 111; also 100 or 101 with we=1.
  - misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
  - out of range: addr[31:2] >= MEM_WORDS.
  - On any error: no array write, rsp_err=1, rsp_rdata=0.
- Store commit: happens on the edge entering RESP, exactly once per request.
  - Byte store writes lane addr[1:0] with wdata[7:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word store writes all four lanes.
  - Unwritten lanes are preserved.
- Load data: captured on the edge entering RESP.
  - The selected byte/half is shifted down to bit 0.
  - Sign-extended for 000/001; zero-extended for 100/101; word loads are passed through.
- Output stability: rsp_rdata and rsp_err are held constant for as long as rsp_valid=1 and rsp_ready=0.
- Reset values (reset=0 at any edge): state=IDLE, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset mid-operation:
  - During WAIT: the transaction is dropped with no array write.
  - During RESP: the response is dropped; a store already committed stays committed.
- Array contents are not reset. Reads of never-written words return 0, because the array is zero-initialised at elaboration.
- Request inputs are ignored whenever req_ready=0. A held req_valid outside IDLE has no effect.

Optional Feature:
- Macro: DMEM_PERF_EN.
- When defined, add three outputs, each 32 bits, reset to 0, saturating at 32'hFFFF_FFFF:
  - rd_count: loads completed without error.
  - wr_count: stores completed without error.
  - err_count: requests completed with rsp_err=1.
- Each counter increments on the response handshake edge.
- When not defined: these ports and counters do not exist, and core behaviour is identical.

Test Plan:
- Word store then load, LATENCY=2 → ack at 3rd cycle after accept with rsp_err=0; load returns 32'hDEADBEEF.
  - Store: addr 0x10, wdata 32'hDEADBEEF, ctrl 010.
  - Load: same address, ctrl 010.
- Sub-word loads from word 32'h8081_7F01 at 0x20:
  - LB 0x23 → 32'hFFFFFF80.
  - LBU 0x23 → 32'h00000080.
  - LH 0x20 → 32'h00007F01.
  - LHU 0x22 → 32'h00008081.
- Byte store SB 0x21 wdata 32'h000000AA onto 32'h11223344 → LW 0x20 returns 32'h1122AA44.
- Error cases → rsp_err=1, rsp_rdata=0, memory unchanged:
  - LW 0x22 (misaligned).
  - SW 0x400 with MEM_WORDS=256 (out of range).
  - ctrl 011 (illegal).
- Backpressure and turnaround:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid stays 1 with stable data, req_ready stays 0.
  - Release rsp_ready → req_ready=1 on the following cycle.
  - LATENCY=0 → rsp_valid in the cycle after accept.
- Reset in WAIT of SW 0x30 wdata 32'h12345678 → outputs at reset values next cycle; LW 0x30 afterwards returns the prior value 32'h0.
